// File: rtl/ptp_exchange_scheduler.sv
// Piezo time-sync exchange scheduler: master ping/echo rounds or slave echo replies
// on a shared single-wire link, with per-session round-trip statistics.
//
// state  | meaning
// IDLE   | no session; waiting for start
// ARM    | slave: waiting (no timeout) for the partner's pulse
// PULSE  | driving pulse_out for PULSE_LEN cycles (c = 0 .. PULSE_LEN-1)
// GUARD  | own-pulse echo mask; echo_in ignored
// LISTEN | timing the partner's pulse until rise or TIMEOUT
// GAP    | master: idle spacing between rounds
module ptp_exchange_scheduler #(
   parameter int CNT_W     = 32,
   parameter int ROUND_W   = 8,
   parameter int PULSE_LEN = 6,
   parameter int GUARD_LEN = 8,
   parameter int TIMEOUT   = 1000,
   parameter int GAP_LEN   = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     master_mode,
   input  logic [ROUND_W-1:0]       rounds_cfg,
   input  logic                     echo_in,
   output logic                     pulse_out,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         last_rtt,
   output logic [CNT_W-1:0]         min_rtt,
   output logic [CNT_W+ROUND_W-1:0] sum_rtt,
   output logic [ROUND_W-1:0]       ok_count,
   output logic [ROUND_W-1:0]       timeout_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_PULSE,
      S_GUARD,
      S_LISTEN,
      S_GAP
   } state_t;

   localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(PULSE_LEN + GUARD_LEN - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_LEN - 1);

   state_t               state;
   state_t               state_nx;
   logic [CNT_W-1:0]     timer;
   logic                 echo_q;
   logic                 rise;
   logic                 role_master;
   logic [ROUND_W-1:0]   rounds_tgt;
   logic [ROUND_W:0]     rounds_after;
   logic                 last_round;
   logic                 timer_clr;
   logic                 accept;
   logic                 meas_ok;
   logic                 meas_to;
   logic                 done_nx;

   assign rise = echo_in & ~echo_q;
   assign busy = (state != S_IDLE);

   // Rounds completed once the round currently ending is counted.
   assign rounds_after = {1'b0, ok_count} + {1'b0, timeout_count} + (ROUND_W+1)'(1);
   assign last_round   = (rounds_after >= {1'b0, rounds_tgt});

   always_comb begin
      state_nx  = state;
      timer_clr = 1'b0;
      accept    = 1'b0;
      meas_ok   = 1'b0;
      meas_to   = 1'b0;
      done_nx   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !stop) begin
               accept    = 1'b1;
               timer_clr = 1'b1;
               state_nx  = master_mode ? S_PULSE : S_ARM;
            end
         end
         S_ARM: begin
            if (rise) begin
               timer_clr = 1'b1;
               state_nx  = S_PULSE;
            end
         end
         S_PULSE: begin
            if (timer == PULSE_END) state_nx = S_GUARD;
         end
         S_GUARD: begin
            if (timer == GUARD_END) state_nx = S_LISTEN;
         end
         S_LISTEN: begin
            // A rise landing on the TIMEOUT cycle itself is still a timeout.
            if (timer >= TIMEOUT_C) meas_to = 1'b1;
            else if (rise)          meas_ok = 1'b1;
            if (meas_ok || meas_to) begin
               if (last_round) begin
                  state_nx = S_IDLE;
                  done_nx  = 1'b1;
               end else if (role_master) begin
                  timer_clr = 1'b1;
                  state_nx  = S_GAP;
               end else if (meas_ok) begin
                  timer_clr = 1'b1;
                  state_nx  = S_PULSE;
               end else begin
                  state_nx = S_ARM;
               end
            end
         end
         S_GAP: begin
            if (timer == GAP_END) begin
               timer_clr = 1'b1;
               state_nx  = S_PULSE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      if (stop) begin
         state_nx = S_IDLE;
         done_nx  = 1'b0;
         meas_ok  = 1'b0;
         meas_to  = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         timer     <= '0;
         echo_q    <= 1'b0;
         pulse_out <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         echo_q    <= echo_in;
         pulse_out <= (state_nx == S_PULSE);
         done      <= done_nx;
         if (timer_clr)        timer <= '0;
         else if (timer != '1) timer <= timer + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         role_master   <= 1'b0;
         rounds_tgt    <= ROUND_W'(1);
         last_rtt      <= '0;
         min_rtt       <= '1;
         sum_rtt       <= '0;
         ok_count      <= '0;
         timeout_count <= '0;
      end else if (accept) begin
         role_master   <= master_mode;
         rounds_tgt    <= (rounds_cfg == '0) ? ROUND_W'(1) : rounds_cfg;
         last_rtt      <= '0;
         min_rtt       <= '1;
         sum_rtt       <= '0;
         ok_count      <= '0;
         timeout_count <= '0;
      end else begin
         if (meas_ok) begin
            last_rtt <= timer;
            if (timer < min_rtt) min_rtt <= timer;
            sum_rtt <= sum_rtt + {{ROUND_W{1'b0}}, timer};
            if (ok_count != '1) ok_count <= ok_count + ROUND_W'(1);
         end
         if (meas_to && (timeout_count != '1)) begin
            timeout_count <= timeout_count + ROUND_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ptp_exchange_scheduler.sv
// Directed bench for ptp_exchange_scheduler: expected session results are queued at
// stimulus time and checked by a monitor whenever done pulses.
module tb_ptp_exchange_scheduler;

   localparam int CNT_W   = 32;
   localparam int ROUND_W = 8;

   logic                     clock = 1'b0;
   logic                     reset = 1'b1;
   logic                     start = 1'b0;
   logic                     stop = 1'b0;
   logic                     master_mode = 1'b0;
   logic [ROUND_W-1:0]       rounds_cfg = '0;
   logic                     echo_in = 1'b0;
   logic                     pulse_out;
   logic                     busy;
   logic                     done;
   logic [CNT_W-1:0]         last_rtt;
   logic [CNT_W-1:0]         min_rtt;
   logic [CNT_W+ROUND_W-1:0] sum_rtt;
   logic [ROUND_W-1:0]       ok_count;
   logic [ROUND_W-1:0]       timeout_count;

   ptp_exchange_scheduler #(
      .CNT_W(CNT_W), .ROUND_W(ROUND_W), .PULSE_LEN(6), .GUARD_LEN(8),
      .TIMEOUT(1000), .GAP_LEN(16)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop),
      .master_mode(master_mode), .rounds_cfg(rounds_cfg), .echo_in(echo_in),
      .pulse_out(pulse_out), .busy(busy), .done(done), .last_rtt(last_rtt),
      .min_rtt(min_rtt), .sum_rtt(sum_rtt), .ok_count(ok_count),
      .timeout_count(timeout_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] last;
      logic [63:0] min;
      logic [63:0] sum;
      logic [63:0] ok;
      logic [63:0] to;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   c = 0;
   int   gap_n;

   localparam logic [63:0] MIN_RST = 64'hFFFF_FFFF;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [63:0] l, input logic [63:0] m, input logic [63:0] s,
                           input logic [63:0] o, input logic [63:0] t);
      exp_t e;
      e.last = l; e.min = m; e.sum = s; e.ok = o; e.to = t;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: every done pulse must match the oldest queued session result.
   always @(negedge clock) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_last_rtt", 64'(last_rtt), e.last);
            check("sb_min_rtt", 64'(min_rtt), e.min);
            check("sb_sum_rtt", 64'(sum_rtt), e.sum);
            check("sb_ok_count", 64'(ok_count), e.ok);
            check("sb_timeout_count", 64'(timeout_count), e.to);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
      c++;
   endtask

   task automatic step_to(input int t);
      while (c < t) step();
   endtask

   task automatic echo_at(input int t);
      step_to(t);
      echo_in = 1'b1;
      step();
      echo_in = 1'b0;
   endtask

   task automatic start_session(input logic m, input logic [ROUND_W-1:0] r);
      master_mode = m;
      rounds_cfg  = r;
      start       = 1'b1;
      step();
      start = 1'b0;
      c     = 0;
   endtask

   task automatic wait_pulse(input int limit, output int n);
      n = 0;
      while (pulse_out !== 1'b1 && n < limit) begin
         step();
         n++;
      end
      check("pulse_start_seen", 64'(pulse_out), 64'd1);
      c = 0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy !== 1'b0 && n < limit) begin
         step();
         n++;
      end
      check("session_idle", 64'(busy), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no_finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #23;
      check("rst_pulse_out", 64'(pulse_out), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_last_rtt", 64'(last_rtt), 64'd0);
      check("rst_min_rtt", 64'(min_rtt), MIN_RST);
      check("rst_sum_rtt", 64'(sum_rtt), 64'd0);
      check("rst_ok_count", 64'(ok_count), 64'd0);
      check("rst_timeout_count", 64'(timeout_count), 64'd0);
      reset = 1'b0;
      step();

      // Master, one round, echo at c=40.
      push_exp(40, 40, 40, 1, 0);
      start_session(1'b1, 8'd1);
      check("t1_pulse_c0", 64'(pulse_out), 64'd1);
      step_to(5);
      check("t1_pulse_c5", 64'(pulse_out), 64'd1);
      step_to(6);
      check("t1_pulse_c6", 64'(pulse_out), 64'd0);
      echo_at(40);
      check("t1_done_c41", 64'(done), 64'd1);
      check("t1_busy_c41", 64'(busy), 64'd0);
      step();
      check("t1_done_one_cycle", 64'(done), 64'd0);

      // Master, three rounds, echoes 30/25/35; a start during the session is ignored.
      push_exp(35, 25, 90, 3, 0);
      start_session(1'b1, 8'd3);
      echo_at(30);
      wait_pulse(40, gap_n);
      check("t2_gap1", 64'(gap_n), 64'd16);
      rounds_cfg = 8'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      echo_at(25);
      wait_pulse(40, gap_n);
      check("t2_gap2", 64'(gap_n), 64'd16);
      echo_at(35);
      wait_idle(50);

      // Master, echo only inside PULSE/GUARD mask: timeout at c=1000.
      push_exp(0, MIN_RST, 0, 0, 1);
      start_session(1'b1, 8'd1);
      step_to(2);
      echo_in = 1'b1;
      step_to(11);
      echo_in = 1'b0;
      step_to(1000);
      check("t3_done_c1000", 64'(done), 64'd0);
      check("t3_busy_c1000", 64'(busy), 64'd1);
      step();
      check("t3_done_c1001", 64'(done), 64'd1);

      // Boundary: rise exactly at c=1000 is a timeout, at c=999 a success.
      push_exp(999, 999, 999, 1, 1);
      start_session(1'b1, 8'd2);
      echo_at(1000);
      wait_pulse(40, gap_n);
      check("tb_gap_after_timeout", 64'(gap_n), 64'd16);
      echo_at(999);
      wait_idle(50);

      // Slave, two rounds.
      push_exp(60, 50, 110, 2, 0);
      start_session(1'b0, 8'd2);
      step_to(5);
      check("t4_arm_no_pulse", 64'(pulse_out), 64'd0);
      check("t4_arm_busy", 64'(busy), 64'd1);
      echo_in = 1'b1;
      step();
      echo_in = 1'b0;
      c = 0;
      check("t4_reply_k1", 64'(pulse_out), 64'd1);
      step_to(5);
      check("t4_reply_k6", 64'(pulse_out), 64'd1);
      step_to(6);
      check("t4_reply_k7", 64'(pulse_out), 64'd0);
      echo_at(50);
      check("t4_reply_after_50", 64'(pulse_out), 64'd1);
      c = 0;
      echo_at(60);
      check("t4_done", 64'(done), 64'd1);
      check("t4_final_not_answered", 64'(pulse_out), 64'd0);
      step();

      // Master stop in LISTEN of round 2; results retained, then a new start clears.
      start_session(1'b1, 8'd2);
      echo_at(30);
      wait_pulse(40, gap_n);
      step_to(20);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t5_stop_busy", 64'(busy), 64'd0);
      check("t5_stop_pulse", 64'(pulse_out), 64'd0);
      check("t5_stop_ok_kept", 64'(ok_count), 64'd1);
      check("t5_stop_last_kept", 64'(last_rtt), 64'd30);
      repeat (5) step();
      push_exp(77, 77, 77, 1, 0);
      start_session(1'b1, 8'd1);
      check("t5_clear_ok", 64'(ok_count), 64'd0);
      check("t5_clear_last", 64'(last_rtt), 64'd0);
      check("t5_clear_min", 64'(min_rtt), MIN_RST);
      check("t5_clear_sum", 64'(sum_rtt), 64'd0);
      echo_at(77);
      wait_idle(50);

      // start and stop in the same cycle: stays idle.
      master_mode = 1'b1;
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      check("t5_start_stop_idle", 64'(busy), 64'd0);

      // Asynchronous reset mid-PULSE, then rounds_cfg=0 runs one round.
      start_session(1'b1, 8'd1);
      step_to(3);
      reset = 1'b1;
      #1;
      check("t6_rst_pulse", 64'(pulse_out), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_done", 64'(done), 64'd0);
      check("t6_rst_min", 64'(min_rtt), MIN_RST);
      check("t6_rst_ok", 64'(ok_count), 64'd0);
      #2;
      reset = 1'b0;
      step();
      push_exp(20, 20, 20, 1, 0);
      start_session(1'b1, 8'd0);
      echo_at(20);
      check("t6_done", 64'(done), 64'd1);
      repeat (30) step();
      check("t6_one_round_only", 64'(busy), 64'd0);

      step();
      check("sb_pending", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
